// File: rtl/alu_seq.sv
// Registered Hack ALU with valid/ready handshakes, a carry/overflow flag and a
// multi-cycle unsigned shift-add multiplier.
module alu_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             zx,
  input  logic             nx,
  input  logic             zy,
  input  logic             ny,
  input  logic             f,
  input  logic             no,
  input  logic             mul,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zr,
  output logic             ng,
  output logic             cy
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [WIDTH-1:0]     r_out;
  logic                 r_zr;
  logic                 r_ng;
  logic                 r_cy;
  logic [2*WIDTH-1:0]   r_acc;
  logic [2*WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]     r_mplier;
  logic [CNT_W-1:0]     r_cnt;

  logic                 w_in_ready;
  logic                 w_accept;
  logic [WIDTH-1:0]     w_xa;
  logic [WIDTH-1:0]     w_xb;
  logic [WIDTH-1:0]     w_ya;
  logic [WIDTH-1:0]     w_yb;
  logic [WIDTH:0]       w_sum;
  logic [WIDTH-1:0]     w_r;
  logic [WIDTH-1:0]     w_hack;
  logic                 w_hack_cy;
  logic [2*WIDTH-1:0]   w_acc_nxt;
  logic                 w_mul_last;

  assign w_in_ready = (r_state == IDLE) || ((r_state == DONE) && out_ready);
  assign w_accept   = in_valid && w_in_ready;

  // Hack ALU datapath on the live input bundle; only used at the accept edge
  always_comb begin
    w_xa      = zx ? {WIDTH{1'b0}} : x;
    w_xb      = nx ? ~w_xa : w_xa;
    w_ya      = zy ? {WIDTH{1'b0}} : y;
    w_yb      = ny ? ~w_ya : w_ya;
    w_sum     = {1'b0, w_xb} + {1'b0, w_yb};
    w_r       = f ? w_sum[WIDTH-1:0] : (w_xb & w_yb);
    w_hack    = no ? ~w_r : w_r;
    w_hack_cy = f & w_sum[WIDTH];
  end

  // One shift-add multiply step; the last step's sum is the final product
  always_comb begin
    w_acc_nxt  = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
    w_mul_last = (r_cnt == CNT_W'(WIDTH - 1));
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt = mul ? MUL : DONE;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      MUL: begin
        if (w_mul_last) begin
          w_state_nxt = DONE;
        end else begin
          w_state_nxt = MUL;
        end
      end
      DONE: begin
        if (w_accept) begin
          w_state_nxt = mul ? MUL : DONE;
        end else if (out_ready) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = DONE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Result registers and multiplier working state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out    <= {WIDTH{1'b0}};
      r_zr     <= 1'b0;
      r_ng     <= 1'b0;
      r_cy     <= 1'b0;
      r_acc    <= {(2*WIDTH){1'b0}};
      r_mcand  <= {(2*WIDTH){1'b0}};
      r_mplier <= {WIDTH{1'b0}};
      r_cnt    <= {CNT_W{1'b0}};
    end else begin
      if (w_accept && !mul) begin
        r_out <= w_hack;
        r_zr  <= (w_hack == {WIDTH{1'b0}});
        r_ng  <= w_hack[WIDTH-1];
        r_cy  <= w_hack_cy;
      end else if ((r_state == MUL) && w_mul_last) begin
        r_out <= w_acc_nxt[WIDTH-1:0];
        r_zr  <= (w_acc_nxt[WIDTH-1:0] == {WIDTH{1'b0}});
        r_ng  <= w_acc_nxt[WIDTH-1];
        r_cy  <= |w_acc_nxt[2*WIDTH-1:WIDTH];
      end
      // Operands are latched once; the multiply never looks at x/y again
      if (w_accept && mul) begin
        r_acc    <= {(2*WIDTH){1'b0}};
        r_mcand  <= {{WIDTH{1'b0}}, x};
        r_mplier <= y;
        r_cnt    <= {CNT_W{1'b0}};
      end else if (r_state == MUL) begin
        r_acc    <= w_acc_nxt;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_cnt    <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = (r_state == DONE);
  assign out       = r_out;
  assign zr        = r_zr;
  assign ng        = r_ng;
  assign cy        = r_cy;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: expectations queued at accept, compared at the
// output handshake, plus direct checks of latency, backpressure and reset.
module tb_alu_seq;

  localparam int W = 16;

  typedef struct packed {
    logic [W-1:0] o;
    logic         zr;
    logic         ng;
    logic         cy;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic         zx, nx, zy, ny, f, no;
  logic         mul;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out;
  logic         zr, ng, cy;

  exp_t sb[$];
  int   hs_cyc[$];
  int   cyc;
  int   n_cmp;
  int   n_bad;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .zx(zx), .nx(nx), .zy(zy), .ny(ny), .f(f), .no(no),
    .mul(mul), .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .zr(zr), .ng(ng), .cy(cy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk_exp(input logic [W-1:0] o, input logic c);
    exp_t e;
    e.o  = o;
    e.zr = (o == 16'h0000);
    e.ng = o[W-1];
    e.cy = c;
    return e;
  endfunction

  // Independent Hack reference in 32-bit integer arithmetic
  function automatic exp_t model_hack(input logic [W-1:0] a, input logic [W-1:0] b,
                                      input logic [5:0] c);
    int xa, xb, ya, yb, s, r, carry;
    xa = c[5] ? 0 : int'(a);
    xb = c[4] ? (xa ^ 32'h0000FFFF) : xa;
    ya = c[3] ? 0 : int'(b);
    yb = c[2] ? (ya ^ 32'h0000FFFF) : ya;
    s  = xb + yb;
    r  = c[1] ? (s & 32'h0000FFFF) : (xb & yb);
    carry = c[1] ? ((s >> 16) & 1) : 0;
    if (c[0]) r = r ^ 32'h0000FFFF;
    return mk_exp(r[15:0], carry[0]);
  endfunction

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      exp_t e;
      hs_cyc.push_back(cyc);
      if (sb.size() == 0) begin
        check_eq("sb_unexpected_out", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        check_eq("out", 64'(out), 64'(e.o));
        check_eq("zr", 64'(zr), 64'(e.zr));
        check_eq("ng", 64'(ng), 64'(e.ng));
        check_eq("cy", 64'(cy), 64'(e.cy));
      end
    end
  end

  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [5:0] c, input logic m);
    x = a; y = b; {zx, nx, zy, ny, f, no} = c; mul = m; in_valid = 1'b1;
  endtask

  // Drive a bundle, hold it until accepted, queue its expectation
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [5:0] c, input logic m, input exp_t e);
    int k;
    drive(a, b, c, m);
    k = 0;
    @(negedge clk);
    while (!in_ready && k < 100) begin
      k++;
      @(negedge clk);
    end
    if (k >= 100) check_eq("accept_timeout", 64'd1, 64'd0);
    sb.push_back(e);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Count negedges before out_valid; in_ready must stay low meanwhile
  task automatic wait_result(output int n);
    logic busy_ok;
    busy_ok = 1'b1;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 100) begin
      if (in_ready) busy_ok = 1'b0;
      n++;
      @(negedge clk);
    end
    if (n >= 100) check_eq("result_timeout", 64'd1, 64'd0);
    check_eq("busy_in_ready_low", 64'(busy_ok), 64'd1);
  endtask

  initial begin
    int n, n0;
    logic [W-1:0] held;
    logic stale;
    logic [5:0] ctl [4];
    cyc = 0; n_cmp = 0; n_bad = 0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    x = 16'h0000; y = 16'h0000; {zx, nx, zy, ny, f, no} = 6'b000000; mul = 1'b0;
    ctl[0] = 6'b000010; ctl[1] = 6'b010011; ctl[2] = 6'b000111; ctl[3] = 6'b000000;

    #12;
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_out", 64'(out), 64'd0);
    check_eq("rst_flags", 64'({zr, ng, cy}), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check_eq("idle_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    send(16'h0011, 16'h0003, 6'b000010, 1'b0, mk_exp(16'h0014, 1'b0));
    wait_result(n);
    check_eq("hack_latency", 64'(n), 64'd0);
    @(posedge clk); #1;
    send(16'h0011, 16'h0003, 6'b010011, 1'b0, mk_exp(16'h000E, 1'b0));
    send(16'h0000, 16'h0003, 6'b111010, 1'b0, mk_exp(16'hFFFF, 1'b0));
    send(16'hFFFF, 16'h0001, 6'b000010, 1'b0, mk_exp(16'h0000, 1'b1));
    repeat (2) @(posedge clk); #1;

    // Multiply with a competing bundle held during the multiply
    send(16'd17, 16'd3, 6'b000000, 1'b1, mk_exp(16'h0033, 1'b0));
    drive(16'h0005, 16'h0006, 6'b000010, 1'b0);
    wait_result(n);
    check_eq("mul_latency", 64'(n), 64'(W));
    check_eq("done_in_ready", 64'(in_ready), 64'd1);
    sb.push_back(mk_exp(16'h000B, 1'b0));
    @(posedge clk); #1 in_valid = 1'b0;
    wait_result(n);
    check_eq("held_hack_latency", 64'(n), 64'd0);
    @(posedge clk); #1;
    send(16'h0100, 16'h0100, 6'b000000, 1'b1, mk_exp(16'h0000, 1'b1));
    wait_result(n);
    @(posedge clk); #1;

    // Backpressure
    out_ready = 1'b0;
    send(16'h1234, 16'h00FF, 6'b000000, 1'b0, mk_exp(16'h0034, 1'b0));
    wait_result(n);
    held = out;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("bp_out_stable", 64'(out), 64'(held));
      check_eq("bp_in_ready", 64'({out_valid, in_ready}), 64'b10);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk); #1;

    // Back-to-back stream
    n0 = hs_cyc.size();
    for (int i = 0; i < 4; i++) begin
      logic [W-1:0] a, b;
      a = W'($urandom);
      b = W'($urandom);
      drive(a, b, ctl[i], 1'b0);
      @(negedge clk);
      check_eq("stream_in_ready", 64'(in_ready), 64'd1);
      sb.push_back(model_hack(a, b, ctl[i]));
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("stream_count", 64'(hs_cyc.size() - n0), 64'd4);
    if (hs_cyc.size() - n0 == 4)
      check_eq("stream_consecutive", 64'(hs_cyc[n0+3] - hs_cyc[n0]), 64'd3);
    @(posedge clk); #1;

    // Reset mid-multiply
    send(16'd17, 16'd3, 6'b000000, 1'b1, mk_exp(16'h0033, 1'b0));
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check_eq("abort_out_valid", 64'(out_valid), 64'd0);
    check_eq("abort_out", 64'(out), 64'd0);
    sb.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check_eq("abort_in_ready", 64'(in_ready), 64'd1);
    stale = 1'b0;
    repeat (24) begin
      @(negedge clk);
      if (out_valid) stale = 1'b1;
    end
    check_eq("abort_no_stale", 64'(stale), 64'd0);
    check_eq("sb_drained", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor to the combinational Hack ALU.
- Same six control bits (zx, nx, zy, ny, f, no) and the same zr/ng flags, at any data width.
- Adds a valid/ready handshake on input and output, a carry/overflow flag, and a multi-cycle unsigned shift-add multiply mode.
- Sits between the CPU datapath/decoder and the writeback register; lets a multi-cycle unit stall the pipeline cleanly.

Parameters:
- WIDTH, 16, data width of x, y, out (>= 2).
- CNT_W, $clog2(WIDTH)+1, multiply iteration counter width (derived; not overridden).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand/control bundle valid.
- in_ready  out  1  block can accept a bundle this cycle.
- x  in  WIDTH  operand x.
- y  in  WIDTH  operand y.
- zx, nx, zy, ny, f, no  in  1 each  Hack ALU control bits; ignored when mul=1.
- mul  in  1  0 = Hack op (1-cycle), 1 = unsigned multiply (WIDTH-cycle).
- out_valid  out  1  result bundle valid.
- out_ready  in  1  consumer accepts result this cycle.
- out  out  WIDTH  result.
- zr  out  1  out == 0.
- ng  out  1  out[WIDTH-1].
- cy  out  1  Hack: carry out of adder when f=1, else 0. Mul: 1 iff product bits [2*WIDTH-1:WIDTH] nonzero.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; out_valid=0; out=0; zr=0; ng=0; cy=0; internal accumulator and counter cleared. Reset during MUL aborts the operation; no result is produced.
- Accept: transfer occurs at a rising edge with in_valid && in_ready. x, y, control and mul are captured at that edge. The source must hold the bundle while in_ready=0; unaccepted bundles are ignored.
- in_ready = (state==IDLE) || (state==DONE && out_ready). This allows back-to-back Hack ops at 1 result/cycle.
- States:
  - IDLE: no result held. On accept with mul=0 -> DONE. On accept with mul=1 -> MUL.
  - MUL: per cycle, if multiplier LSB=1, add the shifted multiplicand into the 2*WIDTH accumulator; shift the multiplicand left and the multiplier right; cnt++. After WIDTH iterations -> DONE.
  - DONE: out_valid=1. If out_ready with no new accept -> IDLE. If out_ready with a new accept: mul=0 stays DONE with the new result; mul=1 -> MUL.
- Latency, accept at edge N: Hack result valid after edge N+1; mul result valid after edge N+WIDTH.
- Hack datapath, exactly per the Hack spec:
  - xa = zx?0:x; xb = nx?~xa:xa; likewise for y.
  - r = f ? xb+yb (WIDTH-bit, carry = bit WIDTH) : xb&yb.
  - out = no ? ~r : r.
  - cy is the adder carry before negation.
- Mul datapath: out = low WIDTH bits of x*y (unsigned); cy = high half nonzero.
- zr and ng are always derived from the registered out value. They are registered together with out and change only when out changes.
- Backpressure: while out_valid && !out_ready, out/zr/ng/cy are held stable and in_ready=0.
- out_valid drops after the handshake edge unless a new Hack result is loaded in the same edge.
- Operands are never re-read after the accept edge; changes to x/y during MUL have no effect.

Test Plan:
- Reset/flags: assert rst_n=0 mid-multiply (x=17, y=3, 5 cycles in) -> out_valid=0, out=0 immediately. After release, in_ready=1 and no stale result appears.
- Hack x+y: WIDTH=16, x=0x0011, y=0x0003, ctrl 000010, out_ready=1 -> one cycle later out=0x0014, zr=0, ng=0, cy=0.
- Hack x-y and -1: same operands, ctrl 010011 -> out=0x000E. Then x=0, ctrl 111010 -> out=0xFFFF, ng=1, cy=0.
- Carry/zero: x=0xFFFF, y=0x0001, ctrl 000010 -> out=0x0000, zr=1, cy=1.
- Multiply:
  - x=17, y=3, mul=1 -> in_ready=0 for 16 cycles, then out=0x0033, cy=0.
  - x=0x0100, y=0x0100 -> out=0x0000, zr=1, cy=1.
- Backpressure/throughput:
  - Hold out_ready=0 for 4 cycles after a result -> out stable, in_ready=0.
  - Then stream 4 Hack ops with out_ready=1 -> 4 results on 4 consecutive cycles.
  - A concurrent in_valid during MUL is not accepted.
